parity_arbiter: RTL and testbench

//  Round-robin scheduler that shares one parity engine (clk/start/data_in/even_parity/odd_parity/busy)

---
 rtl/parity_pkg.sv | 22 ++
 rtl/rr_pick.sv | 38 +++
 rtl/parity_arbiter.sv | 145 ++++++++++++++
 tb/tb_parity_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity arbiter.
//   state_e   : arbiter FSM state encoding
//   DefaultDw : default data width, matches the parity engine data_in
//   parity8() : reference {even, odd} parity of one byte, for benches and models
package parity_pkg;

  localparam int unsigned DefaultDw = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StWaitHi = 3'd2,
    StWaitLo = 3'd3,
    StResp   = 3'd4
  } state_e;

  // even = 1 when the byte holds an even number of ones; odd is its complement.
  function automatic logic [1:0] parity8(input logic [7:0] b);
    parity8 = {~^b, ^b};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: combinational search of the request vector starting at the
// rotating pointer, wrapping at N_REQ.
//   i_req     : request levels
//   i_rr_ptr  : index where the search starts
//   o_win_oh  : one-hot winner (0 when no request)
//   o_win_idx : binary index of the winner
//   o_any     : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_rr_ptr,
  output logic [N_REQ-1:0] o_win_oh,
  output logic [IW-1:0]    o_win_idx,
  output logic             o_any
);

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = (32'(i_rr_ptr) + k) % N_REQ;
      if (!w_found && i_req[IW'(w_idx)]) begin
        w_found               = 1'b1;
        o_win_oh[IW'(w_idx)]  = 1'b1;
        o_win_idx             = IW'(w_idx);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin scheduler sharing one parity engine among N_REQ requesters.
// A winner is chosen in IDLE, its byte is latched onto eng_data, the engine is
// started with a one-cycle pulse, busy rise and fall are awaited (each with a
// timeout), and the result is returned to the owner with a one-cycle rsp_valid.
//   clk, reset        : clock, synchronous active-high reset
//   req, req_data     : per-requester request level and byte
//   gnt               : one-hot owner of the current transaction
//   rsp_valid         : one-hot response pulse to the owner
//   rsp_even/odd/err  : result and timeout flag, held until the next response
//   eng_start/data    : engine start pulse and operand
//   eng_busy/even/odd : engine status and result
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic                rsp_even,
  output logic                rsp_odd,
  output logic                rsp_err,
  output logic                eng_start,
  output logic [DW-1:0]       eng_data,
  input  logic                eng_busy,
  input  logic                eng_even,
  input  logic                eng_odd
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e           r_state;
  state_e           w_state_d;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_rr_ptr;
  logic [DW-1:0]    r_eng_data;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_rsp_even;
  logic             r_rsp_odd;
  logic             r_rsp_err;

  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_any;
  logic             w_tmo_hit;
  logic             w_in_wait;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_win_oh (w_win_oh),
    .o_win_idx(w_win_idx),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_d = r_state;
    w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT - 1));
    w_in_wait = (r_state == StWaitHi) || (r_state == StWaitLo);
    case (r_state)
      StIdle:   if (w_any) w_state_d = StIssue;
      StIssue:  w_state_d = StWaitHi;
      // Busy already high before the start pulse is never seen here: it is
      // only sampled from WAIT_HI onward.
      StWaitHi: begin
        if (eng_busy)       w_state_d = StWaitLo;
        else if (w_tmo_hit) w_state_d = StResp;
      end
      StWaitLo: begin
        if (!eng_busy)      w_state_d = StResp;
        else if (w_tmo_hit) w_state_d = StResp;
      end
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_eng_data <= '0;
      r_tmo_cnt  <= '0;
      r_rsp_even <= 1'b0;
      r_rsp_odd  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_d;

      // Cleared on every state change so each busy edge gets its own budget.
      if (w_in_wait && (w_state_d == r_state)) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      else                                     r_tmo_cnt <= '0;

      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_gnt      <= w_win_oh;
            r_owner    <= w_win_idx;
            r_eng_data <= req_data[w_win_idx*DW +: DW];
          end
        end
        StWaitHi: begin
          if (!eng_busy && w_tmo_hit) begin
            {r_rsp_even, r_rsp_odd, r_rsp_err} <= 3'b001;
          end
        end
        StWaitLo: begin
          if (!eng_busy) begin
            {r_rsp_even, r_rsp_odd, r_rsp_err} <= {eng_even, eng_odd, 1'b0};
          end else if (w_tmo_hit) begin
            {r_rsp_even, r_rsp_odd, r_rsp_err} <= 3'b001;
          end
        end
        StResp: begin
          r_gnt <= '0;
          // Pointer moves past the owner so a still-high owner waits a full rotation.
          if (r_owner == IW'(N_REQ - 1)) r_rr_ptr <= '0;
          else                           r_rr_ptr <= r_owner + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = (r_state == StResp) ? r_gnt : '0;
  assign eng_start = (r_state == StIssue);
  assign eng_data  = r_eng_data;
  assign rsp_even  = r_rsp_even;
  assign rsp_odd   = r_rsp_odd;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_parity_arbiter.sv
// Self-checking bench for parity_arbiter. A behavioural parity engine with
// programmable busy length (or stuck low / stuck high) stands in for the real
// engine. Expected winners come from a round-robin model over the request mask;
// expected parity from population count.
module tb_parity_arbiter;
  import parity_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic            rsp_even, rsp_odd, rsp_err;
  logic            eng_start;
  logic [DW-1:0]   eng_data;
  logic            eng_busy, eng_even, eng_odd;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  // Engine mode: 0 normal, 1 never goes busy, 2 busy sticks high.
  int            eng_mode = 0;
  int            eng_lat  = 1;
  int            eng_cnt;
  logic [DW-1:0] eng_q;

  // Results of the last await_rsp call.
  logic [N-1:0]  a_v, a_gst;
  logic          a_ev, a_od, a_er;
  logic [DW-1:0] a_dst;
  int            a_cyc, a_stc, a_nst;
  bit            a_to;

  parity_arbiter #(
    .N_REQ  (N),
    .DW     (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_even (rsp_even),
    .rsp_odd  (rsp_odd),
    .rsp_err  (rsp_err),
    .eng_start(eng_start),
    .eng_data (eng_data),
    .eng_busy (eng_busy),
    .eng_even (eng_even),
    .eng_odd  (eng_odd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_even <= 1'b0;
      eng_odd  <= 1'b0;
      eng_cnt  <= 0;
    end else if (eng_start && eng_mode != 1) begin
      eng_busy <= 1'b1;
      eng_cnt  <= eng_lat;
      eng_q    <= eng_data;
    end else if (eng_busy && eng_mode != 2) begin
      if (eng_cnt <= 1) begin
        eng_busy             <= 1'b0;
        {eng_even, eng_odd}  <= parity8(eng_q);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Continuous protocol properties.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (eng_start && (|rsp_valid)) begin
        failures++; $display("FAIL start_with_rsp got start=%b rsp_valid=%b exp no overlap", eng_start, rsp_valid);
      end
      checks++;
      if (eng_start && eng_busy) begin
        failures++; $display("FAIL start_with_busy got start=1 busy=1 exp no overlap");
      end
      checks++;
      if (!$onehot0(gnt) || !$onehot0(rsp_valid)) begin
        failures++; $display("FAIL onehot got gnt=%b rsp_valid=%b exp one-hot or zero", gnt, rsp_valid);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic logic exp_even(input logic [DW-1:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic set_slice(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  // Advance negedge by negedge until a response pulse, recording the first start.
  task automatic await_rsp(input int bound);
    a_v = '0; a_gst = '0; a_dst = '0; a_ev = 1'b0; a_od = 1'b0; a_er = 1'b0;
    a_cyc = 0; a_stc = -1; a_nst = 0; a_to = 1'b1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (eng_start) begin
        a_nst++;
        if (a_stc < 0) begin a_stc = c; a_gst = gnt; a_dst = eng_data; end
      end
      if (|rsp_valid) begin
        a_v = rsp_valid; a_ev = rsp_even; a_od = rsp_odd; a_er = rsp_err;
        a_cyc = c; a_to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0; m_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", eng_start); end
    checks++; if (eng_data !== '0) begin failures++; $display("FAIL reset_eng_data got=%h exp=0", eng_data); end
    checks++;
    if ({rsp_even, rsp_odd, rsp_err} !== 3'b000) begin
      failures++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_even, rsp_odd, rsp_err});
    end
    reset = 1'b0; m_ptr = 0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || eng_start !== 1'b0) begin
      failures++; $display("FAIL idle_no_req got gnt=%b start=%b exp 0/0", gnt, eng_start);
    end
  endtask

  task automatic test_single();
    eng_lat = 1;
    set_slice(1, 8'hA5);
    req = 4'b0010;
    await_rsp(40);
    checks++; if (a_to) begin failures++; $display("FAIL single_timeout got no rsp exp rsp"); end
    checks++; if (a_v !== 4'b0010) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0010", a_v); end
    checks++;
    if ({a_ev, a_od, a_er} !== 3'b100) begin
      failures++; $display("FAIL single_result got=%b exp=100", {a_ev, a_od, a_er});
    end
    checks++; if (a_nst !== 1) begin failures++; $display("FAIL single_starts got=%0d exp=1", a_nst); end
    checks++; if (a_stc !== 1) begin failures++; $display("FAIL single_start_lat got=%0d exp=1", a_stc); end
    checks++; if (a_gst !== 4'b0010) begin failures++; $display("FAIL single_gnt got=%b exp=0010", a_gst); end
    checks++; if (a_dst !== 8'hA5) begin failures++; $display("FAIL single_eng_data got=%h exp=a5", a_dst); end
    checks++; if (a_cyc !== 4) begin failures++; $display("FAIL single_turnaround got=%0d exp=4", a_cyc); end
    req = '0; m_ptr = 2;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || rsp_valid !== '0) begin
      failures++; $display("FAIL single_after got gnt=%b rsp_valid=%b exp 0/0", gnt, rsp_valid);
    end
    checks++; if (rsp_even !== 1'b1) begin failures++; $display("FAIL single_hold got=%b exp=1", rsp_even); end
  endtask

  task automatic test_fairness();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    logic exp_odd[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    eng_lat = 1;
    set_slice(0, 8'h01); set_slice(1, 8'h03); set_slice(2, 8'h07); set_slice(3, 8'h0F);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      await_rsp(40);
      checks++;
      if (a_to || a_v !== (N'(1) << exp_idx[i])) begin
        failures++; $display("FAIL fair_owner_%0d got=%b exp=%b", i, a_v, N'(1) << exp_idx[i]);
      end
      checks++;
      if ({a_ev, a_od, a_er} !== {~exp_odd[i], exp_odd[i], 1'b0}) begin
        failures++; $display("FAIL fair_result_%0d got=%b exp=%b", i, {a_ev, a_od, a_er}, {~exp_odd[i], exp_odd[i], 1'b0});
      end
      checks++;
      if (a_cyc !== ((i == 0) ? 4 : 5)) begin
        failures++; $display("FAIL fair_spacing_%0d got=%0d exp=%0d", i, a_cyc, (i == 0) ? 4 : 5);
      end
      m_ptr = (exp_idx[i] + 1) % N;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    eng_lat = 1;
    set_slice(2, 8'h5A);
    req = 4'b0100;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b0100) begin failures++; $display("FAIL wrap_first got=%b exp=0100", a_v); end
    req = '0; m_ptr = 3;
    @(negedge clk);
    set_slice(3, 8'h80); set_slice(0, 8'h81);
    req = 4'b1001;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b1000) begin failures++; $display("FAIL wrap_req3 got=%b exp=1000", a_v); end
    checks++; if ({a_ev, a_od} !== 2'b01) begin failures++; $display("FAIL wrap_req3_par got=%b exp=01", {a_ev, a_od}); end
    req[3] = 1'b0;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b0001) begin failures++; $display("FAIL wrap_req0 got=%b exp=0001", a_v); end
    checks++; if ({a_ev, a_od} !== 2'b10) begin failures++; $display("FAIL wrap_req0_par got=%b exp=10", {a_ev, a_od}); end
    req = '0; m_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    eng_mode = 1;
    set_slice(1, 8'h01); set_slice(2, 8'h07);
    req = 4'b0110;
    await_rsp(TMO + 20);
    checks++; if (a_to || a_v !== 4'b0010) begin failures++; $display("FAIL tmo_hi_owner got=%b exp=0010", a_v); end
    checks++;
    if ({a_ev, a_od, a_er} !== 3'b001) begin
      failures++; $display("FAIL tmo_hi_result got=%b exp=001", {a_ev, a_od, a_er});
    end
    checks++; if (a_cyc !== TMO + 2) begin failures++; $display("FAIL tmo_hi_cycles got=%0d exp=%0d", a_cyc, TMO + 2); end
    req[1] = 1'b0; eng_mode = 0; eng_lat = 2;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b0100) begin failures++; $display("FAIL tmo_next_owner got=%b exp=0100", a_v); end
    checks++;
    if ({a_ev, a_od, a_er} !== 3'b010) begin
      failures++; $display("FAIL tmo_next_result got=%b exp=010", {a_ev, a_od, a_er});
    end
    checks++; if (a_cyc !== 6) begin failures++; $display("FAIL tmo_next_cycles got=%0d exp=6", a_cyc); end
    req = '0; m_ptr = 3;
    @(negedge clk);
    // Busy rises but never falls.
    eng_mode = 2;
    set_slice(0, 8'h03);
    req = 4'b0001;
    await_rsp(TMO + 20);
    checks++; if (a_to || a_v !== 4'b0001) begin failures++; $display("FAIL tmo_lo_owner got=%b exp=0001", a_v); end
    checks++;
    if ({a_ev, a_od, a_er} !== 3'b001) begin
      failures++; $display("FAIL tmo_lo_result got=%b exp=001", {a_ev, a_od, a_er});
    end
    checks++; if (a_cyc !== TMO + 3) begin failures++; $display("FAIL tmo_lo_cycles got=%0d exp=%0d", a_cyc, TMO + 3); end
    req = '0; eng_mode = 0; m_ptr = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit seen = 1'b0;
    eng_lat = 1;
    set_slice(2, 8'h11);
    req = 4'b0100;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b0100) begin failures++; $display("FAIL midop_pre got=%b exp=0100", a_v); end
    req = '0; m_ptr = 3;
    @(negedge clk);
    eng_lat = 4;
    set_slice(1, 8'h01);
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (eng_start) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midop_start got=none exp=start pulse"); end
    repeat (2) @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || rsp_valid !== '0 || eng_start !== 1'b0) begin
      failures++; $display("FAIL midop_reset got gnt=%b rsp_valid=%b start=%b exp 0", gnt, rsp_valid, eng_start);
    end
    reset = 1'b0; m_ptr = 0; eng_lat = 1;
    set_slice(2, 8'h3C); set_slice(3, 8'h01);
    req = 4'b1100;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b0100) begin failures++; $display("FAIL midop_first got=%b exp=0100", a_v); end
    checks++;
    if ({a_ev, a_od, a_er} !== 3'b100) begin
      failures++; $display("FAIL midop_first_res got=%b exp=100", {a_ev, a_od, a_er});
    end
    checks++; if (a_cyc !== 4) begin failures++; $display("FAIL midop_first_cyc got=%0d exp=4", a_cyc); end
    req[2] = 1'b0;
    await_rsp(40);
    checks++; if (a_to || a_v !== 4'b1000) begin failures++; $display("FAIL midop_second got=%b exp=1000", a_v); end
    req = '0; m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    eng_lat = 1;
    set_slice(0, 8'hFF);
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      await_rsp(40);
      checks++; if (a_to || a_v !== 4'b0001) begin failures++; $display("FAIL b2b_owner_%0d got=%b exp=0001", i, a_v); end
      checks++;
      if ({a_ev, a_od, a_er} !== 3'b100) begin
        failures++; $display("FAIL b2b_result_%0d got=%b exp=100", i, {a_ev, a_od, a_er});
      end
      checks++;
      if (a_cyc !== ((i == 0) ? 4 : 5)) begin
        failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, a_cyc, (i == 0) ? 4 : 5);
      end
      checks++; if (a_nst !== 1) begin failures++; $display("FAIL b2b_starts_%0d got=%0d exp=1", i, a_nst); end
    end
    req = '0; m_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0]  mask;
    logic [N-1:0]  eoh;
    logic [DW-1:0] d[N];
    int            e, lat, exp_cyc;
    bit            fresh;
    for (int r = 0; r < 25; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        d[i] = DW'($urandom);
        set_slice(i, d[i]);
      end
      fresh = 1'b1;
      lat = $urandom_range(1, 4);
      eng_lat = lat;
      req = mask;
      while (mask != '0) begin
        e = model_pick(mask, m_ptr);
        eoh = N'(1) << e;
        exp_cyc = (fresh ? 3 : 4) + lat;
        await_rsp(40);
        checks++; if (a_to || a_v !== eoh) begin failures++; $display("FAIL rnd_owner r=%0d got=%b exp=%b", r, a_v, eoh); end
        checks++;
        if ({a_ev, a_od, a_er} !== {exp_even(d[e]), ~exp_even(d[e]), 1'b0}) begin
          failures++;
          $display("FAIL rnd_result r=%0d got=%b exp=%b", r, {a_ev, a_od, a_er}, {exp_even(d[e]), ~exp_even(d[e]), 1'b0});
        end
        checks++;
        if (a_gst !== eoh || a_dst !== d[e]) begin
          failures++; $display("FAIL rnd_issue r=%0d got gnt=%b data=%h exp gnt=%b data=%h", r, a_gst, a_dst, eoh, d[e]);
        end
        checks++; if (a_cyc !== exp_cyc) begin failures++; $display("FAIL rnd_cycles r=%0d got=%0d exp=%0d", r, a_cyc, exp_cyc); end
        req[e] = 1'b0;
        mask[e] = 1'b0;
        m_ptr = (e + 1) % N;
        fresh = 1'b0;
        lat = $urandom_range(1, 4);
        eng_lat = lat;
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
